// File: rtl/stack_pkg.sv
// stack_pkg: shared FSM encoding, opcodes and default sizes for the stack arbiter
package stack_pkg;
    localparam int DW_DEF    = 2;
    localparam int DEPTH_DEF = 256;
    localparam logic OP_PUSH = 1'b0;
    localparam logic OP_POP  = 1'b1;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        ACK     = 2'd3
    } state_e;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin grant with pointer; burst lock when STACK_ARB_LOCK_EN is defined
module rr_arbiter2 (
    input  logic clk,
    input  logic rst,
    input  logic req_a,
    input  logic req_b,
    input  logic take,
    input  logic lock_upd,
    input  logic lock_in,
    input  logic owner,
    output logic gnt_b
);
    logic ptr_q, ptr_d, hold, base;
`ifdef STACK_ARB_LOCK_EN
    logic lock_q, lock_d;
    assign lock_d = lock_upd ? lock_in : lock_q;
    // lock as seen in the owner's last ACK cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) lock_q <= 1'b0;
        else      lock_q <= lock_d;
    end
    assign hold = lock_q && (owner ? req_b : req_a);
`else
    logic unused_lock;
    assign unused_lock = ^{lock_upd, lock_in, owner};
    assign hold = 1'b0;
`endif
    assign base  = (req_a && req_b) ? ptr_q : req_b;
    assign gnt_b = hold ? owner : base;
    assign ptr_d = (take && !hold) ? !gnt_b : ptr_q;
    // pointer moves to the port that was not granted
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ptr_q <= 1'b0;
        else      ptr_q <= ptr_d;
    end
endmodule

// File: rtl/stack_arbiter.sv
// stack_arbiter: round-robin sharing of one direction stack between two requesters; lock via STACK_ARB_LOCK_EN
module stack_arbiter
    import stack_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int CNT_W = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_a,
    input  logic             op_a,
    input  logic [DW-1:0]    wdata_a,
    output logic             ack_a,
    output logic             err_a,
    output logic [DW-1:0]    rdata_a,
    input  logic             req_b,
    input  logic             op_b,
    input  logic [DW-1:0]    wdata_b,
    output logic             ack_b,
    output logic             err_b,
    output logic [DW-1:0]    rdata_b,
    input  logic             lock_a,
    input  logic             lock_b,
    output logic             stk_push,
    output logic             stk_pop,
    output logic [DW-1:0]    stk_din,
    input  logic [DW-1:0]    stk_dout,
    input  logic             stk_empty,
    input  logic             stk_full,
    output logic             busy,
    output logic [CNT_W-1:0] count
);
    if ((2 ** CNT_W) <= DEPTH) begin : g_cnt_w_check
        $error("CNT_W too narrow for DEPTH");
    end

    state_e            state_q, state_d;
    logic              gnt_q, gnt_d, op_q, op_d, rej_q, rej_d, gnt_b, issue;
    logic [DW-1:0]     din_q, din_d, rda_q, rda_d, rdb_q, rdb_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    rr_arbiter2 u_arb (
        .clk      (clk),
        .rst      (rst),
        .req_a    (req_a),
        .req_b    (req_b),
        .take     (state_q == IDLE && (req_a || req_b)),
        .lock_upd (state_q == ACK),
        .lock_in  (gnt_q ? lock_b : lock_a),
        .owner    (gnt_q),
        .gnt_b    (gnt_b)
    );

    // next state: latch the grant, strobe the stack, capture pop data, then ack
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        op_d    = op_q;
        rej_d   = rej_q;
        din_d   = din_q;
        rda_d   = rda_q;
        rdb_d   = rdb_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (req_a || req_b) begin
                state_d = ISSUE;
                gnt_d   = gnt_b;
                op_d    = gnt_b ? op_b : op_a;
                din_d   = gnt_b ? wdata_b : wdata_a;
                rej_d   = (op_d == OP_POP) ? stk_empty : stk_full;
            end
            ISSUE: state_d = CAPTURE;
            CAPTURE: begin
                state_d = ACK;
                if (!rej_q && op_q == OP_POP) begin
                    rda_d = gnt_q ? rda_q : stk_dout;
                    rdb_d = gnt_q ? stk_dout : rdb_q;
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (!rej_q) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // state and datapath registers; reset abandons any transaction in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            gnt_q   <= 1'b0;
            op_q    <= OP_PUSH;
            rej_q   <= 1'b0;
            din_q   <= '0;
            rda_q   <= '0;
            rdb_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            op_q    <= op_d;
            rej_q   <= rej_d;
            din_q   <= din_d;
            rda_q   <= rda_d;
            rdb_q   <= rdb_d;
            cnt_q   <= cnt_d;
        end
    end

    assign issue    = state_q == ISSUE && !rej_q;
    assign stk_push = issue && op_q == OP_PUSH;
    assign stk_pop  = issue && op_q == OP_POP;
    assign ack_a    = state_q == ACK && !gnt_q;
    assign ack_b    = state_q == ACK && gnt_q;
    assign err_a    = ack_a && rej_q;
    assign err_b    = ack_b && rej_q;
    assign busy     = state_q != IDLE;
    assign stk_din  = din_q;
    assign rdata_a  = rda_q;
    assign rdata_b  = rdb_q;
    assign count    = cnt_q;
endmodule

// File: tb/tb_stack_arbiter.sv
// tb_stack_arbiter: directed and random transactions checked against a queue-based model
module tb_stack_arbiter;
    localparam int DW = 2, DEPTH = 256, CNT_W = 9;

    logic clk = 1'b0, rst = 1'b0;
    logic req_a = 0, op_a = 0, req_b = 0, op_b = 0;
    logic [DW-1:0] wdata_a = '0, wdata_b = '0, rdata_a, rdata_b, stk_din, stk_dout;
    logic ack_a, err_a, ack_b, err_b, stk_push, stk_pop, stk_empty, stk_full, busy;
    logic [CNT_W-1:0] count;
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    stack_arbiter #(.DW(DW), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .req_a(req_a), .op_a(op_a), .wdata_a(wdata_a), .ack_a(ack_a), .err_a(err_a), .rdata_a(rdata_a),
        .req_b(req_b), .op_b(op_b), .wdata_b(wdata_b), .ack_b(ack_b), .err_b(err_b), .rdata_b(rdata_b),
        .lock_a(1'b0), .lock_b(1'b0),
        .stk_push(stk_push), .stk_pop(stk_pop), .stk_din(stk_din), .stk_dout(stk_dout),
        .stk_empty(stk_empty), .stk_full(stk_full), .busy(busy), .count(count)
    );

    // environment stack: registered pop data, reset with the arbiter
    logic [DW-1:0] env_mem [DEPTH];
    int env_n;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            env_n    <= 0;
            stk_dout <= '0;
        end else if (stk_push && env_n < DEPTH) begin
            env_mem[env_n] <= stk_din;
            env_n          <= env_n + 1;
        end else if (stk_pop && env_n > 0) begin
            stk_dout <= env_mem[env_n-1];
            env_n    <= env_n - 1;
        end
    end
    assign stk_empty = env_n == 0;
    assign stk_full  = env_n == DEPTH;

    // reference model: LIFO contents, round-robin pointer, last pop data per port
    logic [DW-1:0] ref_q [$];
    bit            ref_ptr;
    logic [DW-1:0] ref_rd [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return {10'b0, ack_a, ack_b, err_a, err_b, stk_push, stk_pop, busy, rdata_a, rdata_b, stk_din, count};
    endfunction

    always @(negedge clk) if (rst) begin
        chk("one_strobe", 32'(stk_push & stk_pop), 0);
        chk("one_ack", 32'(ack_a & ack_b), 0);
    end

    task automatic model_reset();
        ref_q.delete();
        ref_ptr   = 0;
        ref_rd[0] = '0;
        ref_rd[1] = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 0; req_a = 0; req_b = 0;
        model_reset();
        #1 chk("reset_outs", outs(), 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1;
        @(posedge clk); #1;
    endtask

    task automatic serve(input bit p, input logic op, input logic [DW-1:0] wd);
        bit rej;
        int k;
        rej = op ? (ref_q.size() == 0) : (ref_q.size() == DEPTH);
        k = 0;
        forever begin
            @(negedge clk);
            if (k <= 3) chk("busy", 32'(busy), 32'(k != 0));
            if (k == 1) begin
                chk("push_strobe", 32'(stk_push), 32'(!op && !rej));
                chk("pop_strobe", 32'(stk_pop), 32'(op && !rej));
                chk("stk_din", 32'(stk_din), 32'(wd));
            end
            if (ack_a || ack_b) break;
            k++;
            if (k > 8) begin
                checks++;
                failures++;
                $error("FAIL ack_timeout: observed no ack after %0d cycles expected ack at cycle 3", k);
                return;
            end
        end
        chk("ack_latency", k, 3);
        if (!rej) begin
            if (op) ref_rd[p] = ref_q.pop_back();
            else    ref_q.push_back(wd);
        end
        chk("ack_port", {30'b0, ack_a, ack_b}, p ? 32'd1 : 32'd2);
        chk("err_a", 32'(err_a), 32'(!p && rej));
        chk("err_b", 32'(err_b), 32'(p && rej));
        chk("rdata_a", 32'(rdata_a), 32'(ref_rd[0]));
        chk("rdata_b", 32'(rdata_b), 32'(ref_rd[1]));
        chk("count", 32'(count), ref_q.size());
    endtask

    task automatic run(input bit ra, input bit oa, input logic [DW-1:0] wa,
                       input bit rb, input bit ob, input logic [DW-1:0] wb);
        bit first;
        req_a = ra; op_a = oa; wdata_a = wa;
        req_b = rb; op_b = ob; wdata_b = wb;
        first   = (ra && rb) ? ref_ptr : rb;
        ref_ptr = !first;
        serve(first, first ? ob : oa, first ? wb : wa);
        @(posedge clk); #1;
        if (first) req_b = 0; else req_a = 0;
        if (ra && rb) begin
            ref_ptr = first;
            serve(!first, first ? oa : ob, first ? wa : wb);
            @(posedge clk); #1;
            if (first) req_a = 0; else req_b = 0;
        end
    endtask

    initial begin
        do_reset();
        run(1, 0, 2'b10, 0, 0, 2'b00);
        run(1, 0, 2'b01, 0, 0, 2'b00);
        run(1, 0, 2'b11, 0, 0, 2'b00);
        run(0, 0, 2'b00, 1, 1, 2'b00);
        run(0, 0, 2'b00, 1, 1, 2'b00);
        do_reset();
        run(1, 0, 2'b00, 1, 0, 2'b01);
        for (int i = 0; i < 3; i++) run(1, 1, 2'b00, 1, 0, 2'(i));
        do_reset();
        run(1, 1, 2'b00, 0, 0, 2'b00);
        run(0, 0, 2'b00, 1, 1, 2'b00);
        for (int i = 0; i < 40; i++) begin
            bit ra, rb;
            ra = 1'($urandom_range(0, 1));
            rb = 1'($urandom_range(0, 1));
            if (!ra && !rb) ra = 1;
            run(ra, 1'($urandom_range(0, 1)), 2'($urandom), rb, 1'($urandom_range(0, 1)), 2'($urandom));
        end
        do_reset();
        for (int i = 0; i < DEPTH; i++) run(1, 0, 2'($urandom), 0, 0, 2'b00);
        run(1, 0, 2'b01, 0, 0, 2'b00);
        run(0, 0, 2'b00, 1, 0, 2'b10);
        run(0, 0, 2'b00, 1, 1, 2'b00);
        req_a = 1; op_a = 0; wdata_a = 2'b11;
        @(posedge clk); #1;
        chk("mid_push", 32'(stk_push), 1);
        rst = 0; req_a = 0;
        model_reset();
        #1 chk("mid_reset_outs", outs(), 0);
        repeat (3) @(negedge clk) chk("no_ack_in_reset", 32'(ack_a | ack_b), 0);
        rst = 1;
        @(posedge clk); #1;
        run(1, 0, 2'b10, 0, 0, 2'b00);
        run(0, 0, 2'b00, 1, 1, 2'b00);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
